// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a valid/ready byte stream into big-endian 32-bit
// instruction words and writes them to consecutive word addresses of the
// instruction memory. The CPU is held (cpu_hold) for the whole load.
module instr_mem_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q,     state_d;
    logic [31:0]      word_q,      word_d;
    logic [1:0]       byte_idx_q,  byte_idx_d;
    logic [31:0]      cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    // Next-state logic: byte packing, address stepping and word counting.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_cnt == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        // Low two address bits are dropped so every write is word aligned.
                        cur_addr_d  = base_addr & 32'hFFFF_FFFC;
                        remaining_d = word_cnt;
                        byte_idx_d  = 2'd0;
                        state_d     = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // in_ready is high throughout COLLECT, so in_valid alone is the handshake.
                if (in_valid) begin
                    word_d     = {word_q[23:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                cur_addr_d = cur_addr_q + 32'd4;
                byte_idx_d = 2'd0;
                // remaining is at least 1 here; the guard keeps it from ever wrapping.
                if (remaining_q != CNT_ZERO) begin
                    remaining_d = remaining_q - CNT_ONE;
                end else begin
                    remaining_d = CNT_ZERO;
                end
                if (remaining_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= 32'd0;
            byte_idx_q  <= 2'd0;
            cur_addr_q  <= 32'd0;
            remaining_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch free.
    assign in_ready  = (state_q == ST_COLLECT);
    assign mem_we    = (state_q == ST_WRITE);
    assign busy      = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign cpu_hold  = busy;
    assign mem_addr  = cur_addr_q;
    assign mem_wdata = word_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus random
// loads, compared against a queue-based model of the expected memory writes.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] word_cnt = 16'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, mem_we, busy, done, cpu_hold;
    logic [31:0] mem_addr, mem_wdata;

    instr_mem_loader #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_we_cyc = -1;
    int done_before = 0;
    int start_cyc = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter advanced at each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("hold_eq_busy", {63'd0, cpu_hold}, {63'd0, busy});
            if (mem_we) begin
                check_eq("we_expected", {63'd0, exp_addr.size() > 0}, 64'd1);
                if (exp_addr.size() > 0) begin
                    check_eq("we_addr", {32'd0, mem_addr}, {32'd0, exp_addr.pop_front()});
                    check_eq("we_data", {32'd0, mem_wdata}, {32'd0, exp_data.pop_front()});
                end
                last_we_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Model: the n-th word goes to the aligned base + 4n (mod 2^32), bytes MSB first.
    task automatic start_load(input logic [31:0] base, input int cnt);
        for (int w = 0; w < cnt; w++) begin
            exp_addr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * w));
            exp_data.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
        end
        base_addr   = base;
        word_cnt    = 16'(cnt);
        start       = 1'b1;
        start_cyc   = cyc;
        done_before = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", {63'd0, busy}, {63'd0, cnt != 0});
    endtask

    // Feeds n bytes from the stream; toggle alternates in_valid, else pct% valid.
    task automatic feed(input int n, input int pct, input bit toggle, input bit poke);
        int idx = 0;
        int budget = 0;
        bit acc;
        bit tv = 1'b0;
        while (idx < n && budget < 400) begin
            tv = ~tv;
            in_valid = toggle ? tv : ($urandom_range(99) < pct);
            in_data  = stream[idx];
            if (poke) begin
                start     = 1'b1;
                word_cnt  = 16'($urandom_range(1, 9));
                base_addr = $urandom;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        check_eq("feed_complete", 64'(idx), 64'(n));
        in_valid = 1'b0;
        start    = 1'b0;
        for (int i = 0; i < idx; i++) void'(stream.pop_front());
    endtask

    task automatic wait_done(input int cnt);
        int budget = 0;
        while (done_cnt == done_before && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("done_seen", 64'(done_cnt), 64'(done_before + 1));
        if (cnt > 0) check_eq("done_after_we", 64'(done_cyc), 64'(last_we_cyc + 1));
        else         check_eq("done_zero_cnt", 64'(done_cyc), 64'(start_cyc + 1));
        check_eq("writes_drained", 64'(exp_addr.size()), 64'd0);
        check_eq("idle_after_done", {62'd0, busy, done}, 64'd0);
    endtask

    task automatic fill_random(input int nbytes);
        stream.delete();
        for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(255)));
    endtask

    task automatic full_load(input logic [31:0] base, input int cnt, input int pct, input bit toggle, input bit poke);
        start_load(base, cnt);
        feed(4 * cnt, pct, toggle, poke);
        wait_done(cnt);
    endtask

    initial begin
        // 1. Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("rst_mem_we",   {63'd0, mem_we},   64'd0);
        check_eq("rst_busy",     {63'd0, busy},     64'd0);
        check_eq("rst_done",     {63'd0, done},     64'd0);
        check_eq("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
        check_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check_eq("rst_mem_wdata",{32'd0, mem_wdata},64'd0);
        @(posedge clk); #1;

        // 2. Single word, back-to-back bytes
        stream.delete();
        stream.push_back(8'h01); stream.push_back(8'h2A);
        stream.push_back(8'h40); stream.push_back(8'h20);
        full_load(32'h0000_0010, 1, 100, 1'b0, 1'b0);

        // 3. Three words, in_valid toggling, unaligned base
        fill_random(12);
        full_load(32'h0000_0003, 3, 0, 1'b1, 1'b0);

        // 4. Address wrap-around
        fill_random(8);
        full_load(32'hFFFF_FFFC, 2, 70, 1'b0, 1'b0);

        // 5. Zero count, then start held during COLLECT
        stream.delete();
        full_load(32'h0000_1000, 0, 100, 1'b0, 1'b0);
        fill_random(8);
        full_load(32'h0000_2000, 2, 80, 1'b0, 1'b1);

        // 6. Reset after two bytes of word 2
        fill_random(8);
        start_load(32'h0000_3000, 2);
        feed(6, 100, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_busy",     {63'd0, busy},     64'd0);
        check_eq("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check_eq("mid_rst_mem_we",   {63'd0, mem_we},   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abandoned_pending", 64'(exp_addr.size()), 64'd1);
        void'(exp_addr.pop_back());
        void'(exp_data.pop_back());
        stream.delete();
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_rst_no_done", 64'(done_cnt), 64'(done_before));
        fill_random(8);
        full_load(32'h0000_4000, 2, 90, 1'b0, 1'b0);

        // Random loads
        for (int k = 0; k < 20; k++) begin
            int cnt;
            cnt = $urandom_range(0, 4);
            fill_random(4 * cnt);
            full_load($urandom, cnt, $urandom_range(20, 100), 1'b0, k[0]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
